// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command constants, top FSM states and time-to-cycle conversion.
package lcd_pkg;
   localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
   localparam logic [7:0] DISP_OFF      = 8'h08;
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] ENTRY_INC     = 8'h06;
   localparam logic [7:0] DISP_ON       = 8'h0C;
   localparam logic [7:0] SET_DDRAM     = 8'h80;
   localparam logic [7:0] LINE2_OFS     = 8'h40;
   localparam logic [7:0] WAKE          = 8'h30;
   localparam logic [5:0] MAX_COL       = 6'd39;
   localparam logic [7:0] INIT_ROM [8] = '{WAKE, WAKE, WAKE, FUNC_SET_8B2L, DISP_OFF, CLEAR, ENTRY_INC, DISP_ON};
   typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR, DATA, ACK, HOLD_OFF} state_t;
   // per_s is 1e9 for ns or 1e6 for us; result rounds up and is never below 1
   function automatic logic [31:0] to_cycles(longint t, longint hz, longint per_s);
      longint n;
      n = (t * hz + per_s - 1) / per_s;
      return n < 1 ? 32'd1 : n[31:0];
   endfunction
endpackage

// File: rtl/lcd_hd44780_drv_if.sv
// lcd_hd44780_drv_if: character request/ack handshake between requester and LCD driver.
interface lcd_hd44780_drv_if;
   logic       rq_lcd;
   logic       lcd_row;
   logic [5:0] lcd_column;
   logic [7:0] lcd_char;
   logic       ack_lcd;
   modport master(output rq_lcd, lcd_row, lcd_column, lcd_char, input ack_lcd);
   modport slave(input rq_lcd, lcd_row, lcd_column, lcd_char, output ack_lcd);
endinterface

// File: rtl/lcd_bus_write.sv
// lcd_bus_write: one HD44780 byte write as SETUP -> E_HIGH -> HOLD -> EXEC.
module lcd_bus_write #(
   parameter logic [31:0] SETUP_N = 3,
   parameter logic [31:0] EPW_N   = 13,
   parameter logic [31:0] HOLD_N  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rs,
   input  logic [7:0]  data,
   input  logic [31:0] wait_cycles,
   output logic        done,
   output logic        lcd_rs,
   output logic        lcd_e,
   output logic [7:0]  lcd_data
);
   typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_E, PH_HOLD, PH_EXEC} phase_t;
   phase_t      ph;
   logic [31:0] cnt, exec_n;
   // done is the last EXEC cycle, so a back-to-back start adds no gap cycle
   assign done = ph == PH_EXEC && cnt == 0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= PH_IDLE;
         cnt <= '0;
         exec_n <= '0;
         lcd_rs <= 1'b0;
         lcd_e <= 1'b0;
         lcd_data <= '0;
      end else if ((ph == PH_IDLE || done) && start) begin
         ph <= PH_SETUP;
         cnt <= SETUP_N - 1;
         exec_n <= wait_cycles;
         lcd_rs <= rs;
         lcd_data <= data;
      end else if (done) begin
         ph <= PH_IDLE;
      end else if (ph != PH_IDLE && cnt != 0) begin
         cnt <= cnt - 1;
      end else if (ph == PH_SETUP) begin
         ph <= PH_E;
         cnt <= EPW_N - 1;
         lcd_e <= 1'b1;
      end else if (ph == PH_E) begin
         ph <= PH_HOLD;
         cnt <= HOLD_N - 1;
         lcd_e <= 1'b0;
      end else if (ph == PH_HOLD) begin
         ph <= PH_EXEC;
         cnt <= exec_n - 1;
      end
   end
endmodule

// File: rtl/lcd_hd44780_drv.sv
// lcd_hd44780_drv: HD44780 driver with power-on init, then one address+char write per request.
module lcd_hd44780_drv import lcd_pkg::*; #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int T_PWR_US    = 20000,
   parameter int T_CLR_US    = 2000,
   parameter int T_EXEC_US   = 50,
   parameter int T_INIT1_US  = 5000,
   parameter int E_PW_NS     = 260,
   parameter int T_AS_NS     = 60,
   parameter int T_H_NS      = 20,
   parameter int HOLDOFF     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   lcd_hd44780_drv_if.slave req,
   output logic             lcd_ready,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic             lcd_e,
   output logic [7:0]       lcd_data
);
   localparam logic [31:0] N_PWR   = to_cycles(T_PWR_US, CLK_FREQ_HZ, 1_000_000);
   localparam logic [31:0] N_CLR   = to_cycles(T_CLR_US, CLK_FREQ_HZ, 1_000_000);
   localparam logic [31:0] N_EXEC  = to_cycles(T_EXEC_US, CLK_FREQ_HZ, 1_000_000);
   localparam logic [31:0] N_INIT1 = to_cycles(T_INIT1_US, CLK_FREQ_HZ, 1_000_000);
   localparam logic [31:0] N_EPW   = to_cycles(E_PW_NS, CLK_FREQ_HZ, 1_000_000_000);
   localparam logic [31:0] N_AS    = to_cycles(T_AS_NS, CLK_FREQ_HZ, 1_000_000_000);
   localparam logic [31:0] N_H     = to_cycles(T_H_NS, CLK_FREQ_HZ, 1_000_000_000);
   state_t      state;
   logic [2:0]  idx, nidx;
   logic [31:0] cnt, wr_wait;
   logic [7:0]  chr, wr_data;
   logic        wr_start, wr_rs, wr_done;
   assign lcd_rw = 1'b0;
   // writes start on the same edge the FSM changes state, keeping latency at exact write lengths
   always_comb begin
      nidx = state == INIT ? idx + 3'd1 : 3'd0;
      wr_start = 1'b0;
      wr_rs = 1'b0;
      wr_data = INIT_ROM[nidx];
      wr_wait = nidx == 3'd0 ? N_INIT1 : nidx == 3'd5 ? N_CLR : N_EXEC;
      if (state == PWR_WAIT) wr_start = cnt == 0;
      if (state == INIT) wr_start = wr_done && idx != 3'd7;
      if (state == IDLE && req.rq_lcd && req.lcd_column <= MAX_COL) begin
         wr_start = 1'b1;
         wr_data = SET_DDRAM | (req.lcd_row ? LINE2_OFS : 8'h00) | {2'b00, req.lcd_column};
         wr_wait = N_EXEC;
      end
      if (state == ADDR && wr_done) begin
         wr_start = 1'b1;
         wr_rs = 1'b1;
         wr_data = chr;
         wr_wait = N_EXEC;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PWR_WAIT;
         cnt <= N_PWR - 1;
         idx <= '0;
         chr <= '0;
         req.ack_lcd <= 1'b0;
         lcd_ready <= 1'b0;
      end else begin
         req.ack_lcd <= 1'b0;
         case (state)
            PWR_WAIT: if (cnt == 0) state <= INIT; else cnt <= cnt - 1;
            INIT: if (wr_done) begin
               if (idx == 3'd7) begin
                  state <= IDLE;
                  lcd_ready <= 1'b1;
               end else idx <= idx + 3'd1;
            end
            IDLE: if (req.rq_lcd) begin
               chr <= req.lcd_char;
               state <= req.lcd_column <= MAX_COL ? ADDR : ACK;
            end
            ADDR: if (wr_done) state <= DATA;
            DATA: if (wr_done) state <= ACK;
            ACK: begin
               req.ack_lcd <= 1'b1;
               state <= HOLD_OFF;
               cnt <= HOLDOFF - 1;
            end
            HOLD_OFF: if (cnt == 0) state <= IDLE; else cnt <= cnt - 1;
            default: state <= PWR_WAIT;
         endcase
      end
   end
   lcd_bus_write #(.SETUP_N(N_AS), .EPW_N(N_EPW), .HOLD_N(N_H)) u_wr (
      .clk(clk), .rst_n(rst_n), .start(wr_start), .rs(wr_rs), .data(wr_data),
      .wait_cycles(wr_wait), .done(wr_done), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data)
   );
endmodule

// File: tb/tb_lcd_hd44780_drv.sv
// tb_lcd_hd44780_drv: directed vectors for init sequence, request timing, holdoff and reset recovery.
module tb_lcd_hd44780_drv;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       lcd_ready, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;
   lcd_hd44780_drv_if rif();
   lcd_hd44780_drv #(.T_PWR_US(10), .T_CLR_US(4), .T_INIT1_US(4), .T_EXEC_US(1)) dut (
      .clk(clk), .rst_n(rst_n), .req(rif.slave), .lcd_ready(lcd_ready),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic       row;
      logic [5:0] col;
      logic [7:0] chr;
      int         lat;
      int         nw;
      logic [7:0] cmd;
   } vec_t;
   vec_t       v [7];
   logic [7:0] init_exp [8];
   int         cyc = 0, ack_cnt = 0, passed = 0, total = 0;
   logic       e_q = 1'b0, ack_q = 1'b0;
   logic [8:0] wlog [$];
   always @(posedge clk) cyc <= cyc + 1;
   // bus log: one {rs,data} entry per E rising edge
   always @(negedge clk) begin
      e_q <= lcd_e;
      ack_q <= rif.ack_lcd;
      if (lcd_e && !e_q) wlog.push_back({lcd_rs, lcd_data});
      if (rif.ack_lcd && !ack_q) ack_cnt <= ack_cnt + 1;
   end
   task automatic chk(string nm, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask
   task automatic wait_ack(output int c);
      int n = 0;
      while (!rif.ack_lcd && n < 20000) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
   endtask
   task automatic check_init(string tag);
      int c_rel, wb, n;
      wb = wlog.size();
      c_rel = cyc;
      n = 0;
      while (!lcd_e && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_pwr_wait"}, cyc - c_rel, 503);
      chk({tag, "_ready_low_in_init"}, lcd_ready, 0);
      n = 0;
      while (!lcd_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_time"}, cyc - c_rel, 1336);
      chk({tag, "_init_writes"}, wlog.size() - wb, 8);
      for (int i = 0; i < 8; i++)
         if (wlog.size() > wb + i) chk({tag, "_init_byte"}, wlog[wb + i], {1'b0, init_exp[i]});
   endtask
   task automatic send(logic row, logic [5:0] col, logic [7:0] chr, output int lat);
      int c0, c;
      @(negedge clk);
      rif.rq_lcd = 1'b1;
      rif.lcd_row = row;
      rif.lcd_column = col;
      rif.lcd_char = chr;
      @(negedge clk);
      c0 = cyc;
      rif.rq_lcd = 1'b0;
      rif.lcd_char = ~chr;
      rif.lcd_row = ~row;
      wait_ack(c);
      lat = c - c0;
   endtask
   initial begin
      int lat, wb, c1, c2, a, n;
      init_exp = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
      v[0] = '{1'b1, 6'd5,  8'h4C, 135, 2, 8'hC5};
      v[1] = '{1'b0, 6'd0,  8'h41, 135, 2, 8'h80};
      v[2] = '{1'b1, 6'd39, 8'h7A, 135, 2, 8'hE7};
      v[3] = '{1'b0, 6'd39, 8'h20, 135, 2, 8'hA7};
      v[4] = '{1'b0, 6'd40, 8'h55, 1,   0, 8'h00};
      v[5] = '{1'b1, 6'd45, 8'h66, 1,   0, 8'h00};
      v[6] = '{1'b0, 6'd63, 8'h77, 1,   0, 8'h00};
      rif.rq_lcd = 1'b0;
      rif.lcd_row = 1'b0;
      rif.lcd_column = '0;
      rif.lcd_char = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", rif.ack_lcd, 0);
      chk("rst_ready", lcd_ready, 0);
      chk("rst_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_rw", lcd_rw, 0);
      rst_n = 1'b1;
      check_init("init");
      for (int i = 0; i < 7; i++) begin
         wb = wlog.size();
         send(v[i].row, v[i].col, v[i].chr, lat);
         chk("req_latency", lat, v[i].lat);
         @(negedge clk);
         chk("ack_one_cycle", rif.ack_lcd, 0);
         repeat (6) @(negedge clk);
         chk("req_write_count", wlog.size() - wb, v[i].nw);
         if (v[i].nw == 2 && wlog.size() >= wb + 2) begin
            chk("req_addr_cmd", wlog[wb], {1'b0, v[i].cmd});
            chk("req_char_data", wlog[wb + 1], {1'b1, v[i].chr});
         end
      end
      // rq held high: char changed after the first sample, second request waits out holdoff
      wb = wlog.size();
      @(negedge clk);
      rif.rq_lcd = 1'b1;
      rif.lcd_row = 1'b0;
      rif.lcd_column = 6'd10;
      rif.lcd_char = 8'h31;
      @(negedge clk);
      c1 = cyc;
      rif.lcd_char = 8'h32;
      wait_ack(c2);
      chk("held_first_latency", c2 - c1, 135);
      c1 = c2;
      @(negedge clk);
      wait_ack(c2);
      rif.rq_lcd = 1'b0;
      chk("held_ack_spacing", c2 - c1, 140);
      repeat (6) @(negedge clk);
      chk("held_write_count", wlog.size() - wb, 4);
      if (wlog.size() >= wb + 4) begin
         chk("held_addr1", wlog[wb], 9'h08A);
         chk("held_char1", wlog[wb + 1], 9'h131);
         chk("held_addr2", wlog[wb + 2], 9'h08A);
         chk("held_char2", wlog[wb + 3], 9'h132);
      end
      // request pending through reset and init
      rst_n = 1'b0;
      rif.rq_lcd = 1'b1;
      rif.lcd_row = 1'b1;
      rif.lcd_column = 6'd0;
      rif.lcd_char = 8'h58;
      repeat (3) @(negedge clk);
      a = ack_cnt;
      wb = wlog.size();
      rst_n = 1'b1;
      check_init("pend");
      chk("pend_no_ack_in_init", ack_cnt - a, 0);
      c1 = cyc;
      wait_ack(c2);
      rif.rq_lcd = 1'b0;
      chk("pend_latency", c2 - c1, 136);
      repeat (6) @(negedge clk);
      if (wlog.size() >= wb + 10) begin
         chk("pend_addr", wlog[wb + 8], 9'h0C0);
         chk("pend_char", wlog[wb + 9], 9'h158);
      end else chk("pend_write_count", wlog.size() - wb, 10);
      // reset during E_HIGH of a data write
      @(negedge clk);
      rif.rq_lcd = 1'b1;
      rif.lcd_row = 1'b0;
      rif.lcd_column = 6'd1;
      rif.lcd_char = 8'h33;
      @(negedge clk);
      rif.rq_lcd = 1'b0;
      n = 0;
      while (!(lcd_e && lcd_rs) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("mid_data_e_high", lcd_e && lcd_rs, 1);
      a = ack_cnt;
      #2 rst_n = 1'b0;
      #1 chk("mid_e_async_drop", lcd_e, 0);
      repeat (4) @(negedge clk);
      chk("mid_ready_cleared", lcd_ready, 0);
      rst_n = 1'b1;
      check_init("mid");
      repeat (20) @(negedge clk);
      chk("mid_no_ack", ack_cnt - a, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lcd_hd44780_drv.md
# lcd_hd44780_drv

Responder end of the LCD character-request handshake. Accepts `rq_lcd` with a row/column/character triple from a requester such as the message register file, and drives an HD44780-compatible character LCD over an 8-bit write-only bus. For each request it writes the DDRAM address, then the character, then returns a one-cycle `ack_lcd`. It runs the mandatory power-on init sequence after every reset.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency; all delay counts derive from it, rounded up.
- `T_PWR_US`, 20000, power-on wait before the first init write.
- `T_CLR_US`, 2000, execution wait after clear (0x01).
- `T_EXEC_US`, 50, execution wait after every other write; also used after the 2nd and 3rd 0x30.
- `T_INIT1_US`, 5000, wait after the first 0x30.
- `E_PW_NS`, 260 (E high time); `T_AS_NS`, 60 (RS/data setup before E rise); `T_H_NS`, 20 (hold after E fall).
- `HOLDOFF`, 4, cycles after `ack_lcd` during which `rq_lcd` is ignored.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rq_lcd` in 1: request, level-sensitive.
- `lcd_row` in 1: 0 selects line 1, 1 selects line 2.
- `lcd_column` in 6: character position, valid range 0–39.
- `lcd_char` in 8: character code.
- `ack_lcd` out 1: one-cycle completion pulse.
- `lcd_ready` out 1: high once init is complete.
- `lcd_rs` out 1: 0 for command, 1 for data.
- `lcd_rw` out 1: constant 0.
- `lcd_e` out 1: LCD enable strobe.
- `lcd_data` out 8: LCD data bus.

## Operation
- Reset values: `ack_lcd`, `lcd_ready`, `lcd_rs`, `lcd_rw`, `lcd_e` = 0; `lcd_data` = 0x00. All states restart at PWR_WAIT.
- Top FSM states: PWR_WAIT → INIT → IDLE → ADDR → DATA → ACK → HOLDOFF → IDLE.
- PWR_WAIT: count T_PWR, then go to INIT.
- INIT: sends the fixed command ROM in order.
  - 0x30, then wait T_INIT1.
  - 0x30, 0x30, then 0x38 (8-bit, 2 lines, 5x8).
  - 0x08 (display off).
  - 0x01 (clear), then wait T_CLR.
  - 0x06 (entry increment, no shift).
  - 0x0C (display on, cursor off).
  - After the last write completes, `lcd_ready` goes to 1 and stays 1 until reset.
- IDLE: when `rq_lcd`=1, capture row, column and char into internal registers. Later input changes have no effect on the transaction in progress.
  - If column ≤ 39: go to ADDR.
  - If column > 39: no bus activity; go straight to ACK (request discarded but acknowledged).
- ADDR: command write of 0x80 | (row ? 0x40 : 0x00) | column.
- DATA: data write (`lcd_rs`=1) of the captured char.
- ACK: `ack_lcd`=1 for exactly one cycle.
- HOLDOFF: ignore `rq_lcd` for HOLDOFF cycles so the requester can update its outputs, then return to IDLE.
- `rq_lcd` is never sampled outside IDLE. Requests before `lcd_ready` stay pending and are not acknowledged.

## Timing
- Each byte write is SETUP (T_AS) → E_HIGH (E_PW) → HOLD (T_H) → EXEC (T_EXEC, or T_CLR/T_INIT1 where specified).
- `lcd_rs` and `lcd_data` are stable from SETUP entry to HOLD exit. `lcd_e`=1 only in E_HIGH.
- Cycle counts: n = ceil(t·CLK_FREQ_HZ), minimum 1. At 50 MHz: SETUP 3, E_HIGH 13, HOLD 1, EXEC 2500.
- Request latency, IDLE sampling to `ack_lcd`: 1 + 2×(write length) cycles, where write length = SETUP+E_HIGH+HOLD+EXEC. At defaults: 1 + 2×2517 = 5035 cycles.
- Out-of-range column: `ack_lcd` asserts 1 cycle after the IDLE sample.
- Next acceptance is no earlier than HOLDOFF+1 cycles after `ack_lcd`.
- Reset asserted mid-write: `lcd_e` drops to 0 asynchronously, the pending request is lost with no ack, and the full T_PWR plus init sequence reruns.
- All outputs are registered.

## Structure
- Package `lcd_pkg`:
  - command constants: FUNC_SET_8B2L=0x38, DISP_OFF=0x08, CLEAR=0x01, ENTRY_INC=0x06, DISP_ON=0x0C, SET_DDRAM=0x80, LINE2_OFS=0x40, WAKE=0x30;
  - MAX_COL=39;
  - top FSM state enum;
  - function converting ns/µs to cycles.
- Sub-module `lcd_bus_write`:
  - inputs `start`, `rs`, `data`, `wait_cycles`;
  - outputs `done` (1-cycle pulse), `lcd_rs`, `lcd_e`, `lcd_data`;
  - contains the SETUP/E_HIGH/HOLD/EXEC counter.
- Top level: init ROM index, capture registers, top FSM, holdoff counter.

## Test plan
Use CLK_FREQ_HZ=50_000_000 with T_PWR_US=10, T_CLR_US=4, T_INIT1_US=4, T_EXEC_US=1, so EXEC = 50 cycles.
- Reset release → 500 idle cycles, then exactly 8 E pulses with data 30,30,30,38,08,01,06,0C, `lcd_rs`=0 on all; `lcd_ready` rises after the last EXEC.
- Ready, rq with row=1, col=5, char=0x4C → command 0xC5 then data 0x4C with `lcd_rs`=1; single `ack_lcd` pulse 2×67+1 cycles after the IDLE sample.
- rq held high continuously with the char changed right after sampling → the captured char is the one written; the second request is accepted only after 4 holdoff cycles.
- col=45 → no E pulse, `ack_lcd` one cycle after the sample.
- rq asserted during init → no ack before `lcd_ready`; serviced immediately after.
- `rst_n` low during E_HIGH of a data write → `lcd_e`=0 in the same cycle, no ack, init sequence restarts.
